plic_claim_master: RTL and testbench

- mem_if initiator that automates the claim/complete handshake against the PLIC register block.
- When ext_irq is high it reads the claim/complete register, hands the claimed id to the core or a local handler, waits for done, then writes the id back to re-open the gateway.
- Sits between the PLIC's mem_if slave port (via the peripheral crossbar) and the interrupt consumer.
- Adds response timeout detection and a post-complete hold-off that covers the PLIC's 2-flop source synchroniser latency.

---
 rtl/plic_claim_master_pkg.sv | 40 ++++
 rtl/plic_claim_master_if.sv | 23 ++
 rtl/plic_claim_master_timer.sv | 28 ++
 rtl/plic_claim_master.sv | 163 ++++++++++++++++
 tb/tb_plic_claim_master.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/plic_claim_master_pkg.sv
// Shared types for the PLIC claim/complete master: mem_if bus structs, FSM states, claim offset.
// No logic; imported by the interface, the timer and the top.
package plic_claim_master_pkg;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;
  localparam int MEM_MW = MEM_DW / 8;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_e;

  typedef struct packed {
    logic [MEM_AW-1:0] req_addr;
    logic [MEM_DW-1:0] req_data;
    logic [MEM_MW-1:0] req_mask;
    mem_type_e         req_type;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DW-1:0] resp_data;
  } mem_resp_t;

  typedef enum logic [2:0] {
    CM_IDLE,
    CM_RD_REQ,
    CM_RD_RESP,
    CM_SERVE,
    CM_WR_REQ,
    CM_WR_RESP,
    CM_HOLD
  } plic_cm_state_e;

  // Claim/complete register sits after priority, pending and enable words.
  function automatic logic [MEM_AW-1:0] plic_claim_offset(input int irq_n);
    return MEM_AW'((irq_n + 3) * 4);
  endfunction

endpackage

// File: rtl/plic_claim_master_if.sv
// mem_if request/response channel between the claim master (initiator) and the PLIC side.
// Valid/ready on both channels; the initiator holds request fields stable until accepted.
interface plic_claim_master_if;
  import plic_claim_master_pkg::*;

  logic      mem_req_valid;
  logic      mem_req_ready;
  mem_req_t  mem_req;
  logic      mem_resp_valid;
  logic      mem_resp_ready;
  mem_resp_t mem_resp;

  modport master (
    output mem_req_valid, mem_req, mem_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_resp
  );

  modport slave (
    input  mem_req_valid, mem_req, mem_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_resp
  );

endinterface

// File: rtl/plic_claim_master_timer.sv
// Loadable down-counter with a zero flag; serves both response timeout and post-complete hold-off.
// Load takes priority over decrement; the count saturates at zero.
module plic_claim_master_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/plic_claim_master.sv
// Automates PLIC claim (read), hand-off to the consumer, and complete (write-back) over mem_if.
// ext_irq to irq_valid in 3 cycles minimum; waits indefinitely on mem_req_ready, times out on responses.
module plic_claim_master
  import plic_claim_master_pkg::*;
#(
  parameter int          PLIC_IRQ_N   = 32,
  parameter int          PLIC_CLAIM_W = $clog2(PLIC_IRQ_N + 1),
  parameter logic [31:0] PLIC_BASE    = 32'h0,
  parameter int          RESP_TIMEOUT = 64,
  parameter int          HOLDOFF      = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    ext_irq,
  plic_claim_master_if.master     mem,
  output logic                    irq_valid,
  output logic [PLIC_CLAIM_W-1:0] irq_id,
  input  logic                    irq_done,
  output logic                    busy,
  output logic                    err,
  input  logic                    err_clr
);

  localparam logic [MEM_AW-1:0] CLAIM_ADDR = PLIC_BASE + plic_claim_offset(PLIC_IRQ_N);
  localparam int TW = $clog2(((RESP_TIMEOUT > HOLDOFF) ? RESP_TIMEOUT : HOLDOFF) + 1);
  // Both loads are count-minus-one: the zero cycle is itself the last waiting cycle.
  localparam logic [TW-1:0] TMO_LOAD  = TW'(RESP_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLDOFF - 1);

  plic_cm_state_e state_q;
  logic           req_vld_q;
  logic           resp_rdy_q;
  mem_req_t       req_q;
  logic           err_q;

  logic           tmr_load;
  logic           tmr_dec;
  logic [TW-1:0]  tmr_val;
  logic           tmr_done;
  logic           in_resp;
  logic           tmo;

  logic [PLIC_CLAIM_W-1:0] resp_id;
  logic                    unused_resp_hi;

  assign resp_id        = mem.mem_resp.resp_data[PLIC_CLAIM_W-1:0];
  assign unused_resp_hi = ^mem.mem_resp.resp_data[MEM_DW-1:PLIC_CLAIM_W];

  assign in_resp = (state_q == CM_RD_RESP) || (state_q == CM_WR_RESP);
  // A response on the expiry cycle wins over the timeout.
  assign tmo     = in_resp && !mem.mem_resp_valid && tmr_done;

  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    case (state_q)
      CM_RD_REQ, CM_WR_REQ: begin
        if (mem.mem_req_ready) begin
          tmr_load = 1'b1;
          tmr_val  = TMO_LOAD;
        end
      end
      CM_RD_RESP, CM_WR_RESP: begin
        if (mem.mem_resp_valid || tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      CM_HOLD: tmr_dec = 1'b1;
      default: ;
    endcase
  end

  plic_claim_master_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= CM_IDLE;
      req_vld_q  <= 1'b0;
      resp_rdy_q <= 1'b0;
      req_q      <= '0;
      irq_valid  <= 1'b0;
      irq_id     <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= tmo | (err_q & ~err_clr);
      case (state_q)
        CM_IDLE: begin
          if (en && ext_irq) begin
            state_q   <= CM_RD_REQ;
            req_vld_q <= 1'b1;
            req_q     <= '{CLAIM_ADDR, {MEM_DW{1'b0}}, {MEM_MW{1'b1}}, MEM_READ};
          end
        end
        CM_RD_REQ: begin
          if (mem.mem_req_ready) begin
            state_q    <= CM_RD_RESP;
            req_vld_q  <= 1'b0;
            resp_rdy_q <= 1'b1;
          end
        end
        CM_RD_RESP: begin
          if (mem.mem_resp_valid) begin
            resp_rdy_q <= 1'b0;
            irq_id     <= resp_id;
            if (resp_id == '0) begin
              state_q <= CM_HOLD;
            end else begin
              state_q   <= CM_SERVE;
              irq_valid <= 1'b1;
            end
          end else if (tmr_done) begin
            resp_rdy_q <= 1'b0;
            state_q    <= CM_HOLD;
          end
        end
        CM_SERVE: begin
          if (irq_done) begin
            state_q   <= CM_WR_REQ;
            irq_valid <= 1'b0;
            req_vld_q <= 1'b1;
            req_q     <= '{CLAIM_ADDR, MEM_DW'(irq_id), {MEM_MW{1'b1}}, MEM_WRITE};
          end
        end
        CM_WR_REQ: begin
          if (mem.mem_req_ready) begin
            state_q    <= CM_WR_RESP;
            req_vld_q  <= 1'b0;
            resp_rdy_q <= 1'b1;
          end
        end
        CM_WR_RESP: begin
          if (mem.mem_resp_valid || tmr_done) begin
            resp_rdy_q <= 1'b0;
            state_q    <= CM_HOLD;
          end
        end
        CM_HOLD: begin
          if (tmr_done) state_q <= CM_IDLE;
        end
        default: state_q <= CM_IDLE;
      endcase
    end
  end

  assign mem.mem_req_valid  = req_vld_q;
  assign mem.mem_req        = req_q;
  assign mem.mem_resp_ready = resp_rdy_q;
  assign busy               = (state_q != CM_IDLE);
  assign err                = err_q;

endmodule

// File: tb/tb_plic_claim_master.sv
// Directed bench for plic_claim_master: claim flow, request stall, spurious claim, timeouts, reset.
// Inputs change and outputs are observed on the falling clock edge.
module tb_plic_claim_master;
  import plic_claim_master_pkg::*;

  localparam logic [31:0] CLAIM = 32'h0000_008C;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       ext_irq = 1'b0;
  logic       irq_done = 1'b0;
  logic       err_clr = 1'b0;
  logic       irq_valid;
  logic [5:0] irq_id;
  logic       busy;
  logic       err;

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  mem_req_t exp_rd;
  mem_req_t exp_wr;

  plic_claim_master_if mif();

  plic_claim_master #(
    .PLIC_IRQ_N(32), .PLIC_BASE(32'h0), .RESP_TIMEOUT(64), .HOLDOFF(3)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .ext_irq(ext_irq), .mem(mif.master),
    .irq_valid(irq_valid), .irq_id(irq_id), .irq_done(irq_done),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rstn && mif.mem_req_valid && mif.mem_req_ready) begin
      if (mif.mem_req.req_type == MEM_READ) rd_cnt++;
      else wr_cnt++;
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    nxt(); nxt();
    total++;
    if ({mif.mem_req_valid, mif.mem_resp_ready, irq_valid, busy, err} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000",
        {mif.mem_req_valid, mif.mem_resp_ready, irq_valid, busy, err});
    end
    total++;
    if (irq_id !== 6'd0 || mif.mem_req !== '0) begin
      bad++; $display("FAIL reset_regs irq_id=%0d req=%h want 0", irq_id, mif.mem_req);
    end
    rstn = 1'b1;
    en = 1'b0; ext_irq = 1'b1; mif.mem_resp_valid = 1'b1;
    nxt(); nxt();
    total++;
    if ({busy, mif.mem_req_valid, mif.mem_resp_ready} !== 3'b000) begin
      bad++; $display("FAIL en_low_idle got=%b want=000", {busy, mif.mem_req_valid, mif.mem_resp_ready});
    end
    ext_irq = 1'b0; mif.mem_resp_valid = 1'b0;
  endtask

  task automatic test_claim_flow();
    int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    en = 1'b1; mif.mem_req_ready = 1'b1; ext_irq = 1'b1;
    nxt();
    total++;
    if (mif.mem_req_valid !== 1'b1 || mif.mem_req !== exp_rd || busy !== 1'b1) begin
      bad++; $display("FAIL claim_read_req vld=%b req=%h busy=%b want 1 %h 1",
        mif.mem_req_valid, mif.mem_req, busy, exp_rd);
    end
    ext_irq = 1'b0;
    nxt();
    total++;
    if ({mif.mem_req_valid, mif.mem_resp_ready, irq_valid} !== 3'b010) begin
      bad++; $display("FAIL claim_rd_resp got=%b want=010", {mif.mem_req_valid, mif.mem_resp_ready, irq_valid});
    end
    mif.mem_resp_valid = 1'b1; mif.mem_resp.resp_data = 32'hFFFF_FFC5;
    nxt();
    mif.mem_resp_valid = 1'b0;
    total++;
    if (irq_valid !== 1'b1 || irq_id !== 6'd5 || mif.mem_resp_ready !== 1'b0) begin
      bad++; $display("FAIL claim_serve vld=%b id=%0d rdy=%b want 1 5 0", irq_valid, irq_id, mif.mem_resp_ready);
    end
    nxt();
    total++;
    if (irq_valid !== 1'b1 || irq_id !== 6'd5) begin
      bad++; $display("FAIL serve_stable vld=%b id=%0d want 1 5", irq_valid, irq_id);
    end
    irq_done = 1'b1;
    nxt();
    irq_done = 1'b0;
    exp_wr = '{CLAIM, 32'd5, 4'hF, MEM_WRITE};
    total++;
    if (irq_valid !== 1'b0 || mif.mem_req_valid !== 1'b1 || mif.mem_req !== exp_wr) begin
      bad++; $display("FAIL complete_write irq_vld=%b vld=%b req=%h want 0 1 %h",
        irq_valid, mif.mem_req_valid, mif.mem_req, exp_wr);
    end
    nxt();
    total++;
    if ({mif.mem_resp_ready, mif.mem_req_valid} !== 2'b10) begin
      bad++; $display("FAIL wr_resp got=%b want=10", {mif.mem_resp_ready, mif.mem_req_valid});
    end
    mif.mem_resp_valid = 1'b1; mif.mem_resp.resp_data = 32'hDEAD_0000; ext_irq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      mif.mem_resp_valid = 1'b0;
      total++;
      if ({busy, mif.mem_req_valid, mif.mem_resp_ready} !== 3'b100) begin
        bad++; $display("FAIL hold_%0d got=%b want=100", i, {busy, mif.mem_req_valid, mif.mem_resp_ready});
      end
    end
    nxt();
    ext_irq = 1'b0;
    total++;
    if ({busy, mif.mem_req_valid} !== 2'b00) begin
      bad++; $display("FAIL hold_exit got=%b want=00", {busy, mif.mem_req_valid});
    end
    nxt();
    total++;
    if (rd_cnt - r0 != 1 || wr_cnt - w0 != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL claim_counts rd=%0d wr=%0d busy=%b want 1 1 0", rd_cnt - r0, wr_cnt - w0, busy);
    end
  endtask

  task automatic test_stall_and_spurious();
    int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    mif.mem_req_ready = 1'b0; ext_irq = 1'b1;
    nxt();
    ext_irq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (mif.mem_req_valid !== 1'b1 || mif.mem_req !== exp_rd) begin
        bad++; $display("FAIL stall_%0d vld=%b req=%h want 1 %h", i, mif.mem_req_valid, mif.mem_req, exp_rd);
      end
      nxt();
    end
    mif.mem_req_ready = 1'b1;
    nxt();
    total++;
    if (rd_cnt - r0 != 1 || mif.mem_resp_ready !== 1'b1 || mif.mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL stall_accept reads=%0d rdy=%b vld=%b want 1 1 0",
        rd_cnt - r0, mif.mem_resp_ready, mif.mem_req_valid);
    end
    mif.mem_resp_valid = 1'b1; mif.mem_resp.resp_data = 32'h0000_0040;
    for (int i = 0; i < 3; i++) begin
      nxt();
      mif.mem_resp_valid = 1'b0;
      total++;
      if ({busy, irq_valid, mif.mem_req_valid} !== 3'b100) begin
        bad++; $display("FAIL spurious_hold_%0d got=%b want=100", i, {busy, irq_valid, mif.mem_req_valid});
      end
    end
    nxt();
    total++;
    if (busy !== 1'b0 || wr_cnt != w0 || irq_id !== 6'd0) begin
      bad++; $display("FAIL spurious_end busy=%b writes=%0d id=%0d want 0 0 0", busy, wr_cnt - w0, irq_id);
    end
  endtask

  task automatic test_timeout();
    int w0;
    w0 = wr_cnt;
    ext_irq = 1'b1;
    nxt();
    ext_irq = 1'b0;
    nxt();
    for (int i = 1; i < 64; i++) nxt();
    total++;
    if (mif.mem_resp_ready !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL tmo_last_wait rdy=%b err=%b want 1 0", mif.mem_resp_ready, err);
    end
    nxt();
    total++;
    if (err !== 1'b1 || mif.mem_resp_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL tmo_expire err=%b rdy=%b busy=%b want 1 0 1", err, mif.mem_resp_ready, busy);
    end
    nxt(); nxt(); nxt();
    total++;
    if (busy !== 1'b0 || err !== 1'b1 || wr_cnt != w0) begin
      bad++; $display("FAIL tmo_idle busy=%b err=%b writes=%0d want 0 1 0", busy, err, wr_cnt - w0);
    end
    err_clr = 1'b1;
    nxt();
    err_clr = 1'b0;
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL err_clr err=%b want 0", err);
    end
    ext_irq = 1'b1;
    nxt();
    ext_irq = 1'b0;
    nxt();
    err_clr = 1'b1;
    for (int i = 1; i < 64; i++) nxt();
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL tmo2_pre err=%b want 0", err);
    end
    nxt();
    err_clr = 1'b0;
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL set_beats_clr err=%b want 1", err);
    end
    nxt(); nxt(); nxt();
    err_clr = 1'b1;
    nxt();
    err_clr = 1'b0;
    total++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL tmo2_idle busy=%b err=%b want 0 0", busy, err);
    end
  endtask

  task automatic test_expiry_response();
    ext_irq = 1'b1;
    nxt();
    ext_irq = 1'b0;
    nxt();
    for (int i = 1; i < 64; i++) nxt();
    mif.mem_resp_valid = 1'b1; mif.mem_resp.resp_data = 32'd9;
    nxt();
    mif.mem_resp_valid = 1'b0;
    total++;
    if (irq_valid !== 1'b1 || irq_id !== 6'd9 || err !== 1'b0) begin
      bad++; $display("FAIL expiry_resp vld=%b id=%0d err=%b want 1 9 0", irq_valid, irq_id, err);
    end
    irq_done = 1'b1;
    nxt();
    irq_done = 1'b0;
    exp_wr = '{CLAIM, 32'd9, 4'hF, MEM_WRITE};
    total++;
    if (mif.mem_req_valid !== 1'b1 || mif.mem_req !== exp_wr) begin
      bad++; $display("FAIL expiry_write vld=%b req=%h want 1 %h", mif.mem_req_valid, mif.mem_req, exp_wr);
    end
    nxt();
    mif.mem_resp_valid = 1'b1;
    nxt();
    mif.mem_resp_valid = 1'b0;
    nxt(); nxt(); nxt();
    total++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL expiry_end busy=%b err=%b want 0 0", busy, err);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    ext_irq = 1'b1;
    nxt();
    ext_irq = 1'b0;
    nxt();
    mif.mem_resp_valid = 1'b1; mif.mem_resp.resp_data = 32'd7;
    nxt();
    mif.mem_resp_valid = 1'b0; mif.mem_req_ready = 1'b0; irq_done = 1'b1;
    nxt();
    irq_done = 1'b0;
    w0 = wr_cnt;
    exp_wr = '{CLAIM, 32'd7, 4'hF, MEM_WRITE};
    total++;
    if (mif.mem_req_valid !== 1'b1 || mif.mem_req !== exp_wr) begin
      bad++; $display("FAIL pre_reset_wr vld=%b req=%h want 1 %h", mif.mem_req_valid, mif.mem_req, exp_wr);
    end
    rstn = 1'b0;
    nxt();
    total++;
    if ({mif.mem_req_valid, busy, irq_valid} !== 3'b000 || irq_id !== 6'd0 || mif.mem_req !== '0) begin
      bad++; $display("FAIL mid_reset flags=%b id=%0d req=%h want 000 0 0",
        {mif.mem_req_valid, busy, irq_valid}, irq_id, mif.mem_req);
    end
    rstn = 1'b1;
    nxt();
    irq_done = 1'b1;
    nxt();
    irq_done = 1'b0;
    nxt();
    total++;
    if ({busy, irq_valid, mif.mem_req_valid} !== 3'b000 || wr_cnt != w0) begin
      bad++; $display("FAIL done_in_idle flags=%b writes=%0d want 000 0",
        {busy, irq_valid, mif.mem_req_valid}, wr_cnt - w0);
    end
    mif.mem_req_ready = 1'b1;
  endtask

  initial begin
    mif.mem_req_ready = 1'b0;
    mif.mem_resp_valid = 1'b0;
    mif.mem_resp = '0;
    exp_rd = '{CLAIM, 32'd0, 4'hF, MEM_READ};
    exp_wr = '0;
    test_reset();
    test_claim_flow();
    test_stall_and_spurious();
    test_timeout();
    test_expiry_response();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog time limit reached total=%0d", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
